// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit
// Description : Architectural HI/LO registers with writeback ports and an
//               iterative radix-2 restoring divider for DIV/DIVU.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    input  logic        div_annul,
    input  logic        wb_hi_we,
    input  logic        wb_lo_we,
    input  logic [63:0] wb_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_busy,
    output logic        div_done
);

    localparam int c_cw = $clog2(DIV_CYCLES);
    localparam logic [c_cw-1:0] c_last = c_cw'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_cw-1:0]   r_cnt;
    logic [63:0]       r_acc;   // {partial remainder, dividend/quotient}
    logic [31:0]       r_b;
    logic              r_qneg;
    logic              r_rneg;
    logic              r_dbz;
    logic              r_done;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;

    logic [31:0]       w_abs_a;
    logic [31:0]       w_abs_b;
    logic [32:0]       w_top;
    logic              w_ge;
    logic [31:0]       w_sub;
    logic [63:0]       w_step;
    logic [31:0]       w_quo_fix;
    logic [31:0]       w_rem_fix;

    assign w_abs_a = (div_signed && div_a[31]) ? -div_a : div_a;
    assign w_abs_b = (div_signed && div_b[31]) ? -div_b : div_b;

    // Shifted remainder may need 33 bits when the divisor exceeds 2^31; the
    // difference is always below the divisor, so 32-bit subtraction suffices.
    assign w_top  = r_acc[63:31];
    assign w_ge   = (w_top >= {1'b0, r_b});
    assign w_sub  = w_top[31:0] - r_b;
    assign w_step = w_ge ? {w_sub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

    assign w_quo_fix = r_qneg ? -r_acc[31:0]  : r_acc[31:0];
    assign w_rem_fix = r_rneg ? -r_acc[63:32] : r_acc[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dbz   <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            if (wb_hi_we) r_hi <= wb_data[63:32];
            if (wb_lo_we) r_lo <= wb_data[31:0];

            case (r_state)
                S_IDLE: begin
                    if (div_start && !div_annul) begin
                        r_acc   <= {32'd0, w_abs_a};
                        r_b     <= w_abs_b;
                        r_qneg  <= div_signed & (div_a[31] ^ div_b[31]);
                        r_rneg  <= div_signed & div_a[31];
                        r_cnt   <= '0;
                        r_dbz   <= (div_b == 32'd0);
                        r_state <= (div_b == 32'd0) ? S_FIN : S_DIV;
                    end
                end
                S_DIV: begin
                    if (div_annul) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last) r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (div_annul) begin
                        r_state <= S_IDLE;
                    end else if (r_dbz && r_cnt == '0) begin
                        // Divide-by-zero idles one extra FIN cycle before its done pulse.
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // Placed after the writeback updates so the divide result wins.
                        if (!r_dbz) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_done = r_done;
    assign div_busy = (r_state != S_IDLE) | (div_start & ~div_annul);

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_div_unit
// Description : Scoreboard bench for hilo_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_annul;
    logic        wb_hi_we;
    logic        wb_lo_we;
    logic [63:0] wb_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_busy;
    logic        div_done;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_spurious = 0;
    logic [63:0] sb[$];

    hilo_div_unit #(.DIV_CYCLES(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_annul  (div_annul),
        .wb_hi_we   (wb_hi_we),
        .wb_lo_we   (wb_lo_we),
        .wb_data    (wb_data),
        .hi         (hi),
        .lo         (lo),
        .div_busy   (div_busy),
        .div_done   (div_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results are popped from the scoreboard whenever the unit signals done.
    always @(negedge clk) begin
        if (div_done === 1'b1) begin
            n_done++;
            if (sb.size() != 0) check("result", {hi, lo}, sb.pop_front());
            else n_spurious++;
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        div_signed = sgn;
        div_a      = a;
        div_b      = b;
        div_start  = 1'b1;
        #1 check("busy_at_start", {63'd0, div_busy}, 64'd1);
        @(posedge clk);
        #1 div_start = 1'b0;
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat);
        int n;
        sb.push_back(exp);
        start_div(sgn, a, b);
        n = 0;
        while (div_busy && n < 100) begin
            step();
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        check("done_high", {63'd0, div_done}, 64'd1);
        step();
        check("done_one_cycle", {63'd0, div_done}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int sa, sbv, done_before;

        rst = 1'b1; div_start = 1'b0; div_signed = 1'b0; div_a = '0; div_b = '0;
        div_annul = 1'b0; wb_hi_we = 1'b0; wb_lo_we = 1'b0; wb_data = '0;
        step(2);
        rst = 1'b0;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_flags", {62'd0, div_busy, div_done}, 64'd0);

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, {32'h7FFF_FFFE, 32'd1}, 33);

        // Preload then divide by zero: hi/lo must survive the done pulse.
        wb_data = {32'h1111_1111, 32'h2222_2222};
        wb_hi_we = 1'b1; wb_lo_we = 1'b1;
        step();
        wb_hi_we = 1'b0; wb_lo_we = 1'b0;
        check("wb_preload", {hi, lo}, {32'h1111_1111, 32'h2222_2222});
        run_div(1'b0, 32'd55, 32'd0, {32'h1111_1111, 32'h2222_2222}, 2);

        // Annul mid-divide.
        done_before = n_done;
        start_div(1'b0, 32'd100, 32'd7);
        step(9);
        div_annul = 1'b1;
        step();
        div_annul = 1'b0;
        check("annul_busy", {63'd0, div_busy}, 64'd0);
        check("annul_hilo", {hi, lo}, {32'h1111_1111, 32'h2222_2222});
        step(40);
        check("annul_no_done", 64'(n_done), 64'(done_before));
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Writeback of HI on the same edge as the FIN write.
        sb.push_back({32'd2, 32'd14});
        start_div(1'b0, 32'd100, 32'd7);
        step(32);
        wb_data = {32'hAAAA_5555, 32'd0}; wb_hi_we = 1'b1;
        step();
        wb_hi_we = 1'b0;
        check("fin_beats_wb", {hi, lo}, {32'd2, 32'd14});
        step(2);

        // Writeback of HI at N+5 stays until the divide result lands.
        wb_data = {32'd0, 32'd0}; wb_lo_we = 1'b1;
        step();
        wb_lo_we = 1'b0;
        sb.push_back({32'd2, 32'd14});
        start_div(1'b0, 32'd100, 32'd7);
        step(4);
        wb_data = {32'hAAAA_5555, 32'd0}; wb_hi_we = 1'b1;
        step();
        wb_hi_we = 1'b0;
        check("wb_mid_divide", {32'd0, hi}, {32'd0, 32'hAAAA_5555});
        step(27);
        check("wb_held_to_n32", {hi, lo}, {32'hAAAA_5555, 32'd0});
        step();
        check("result_after_wb", {hi, lo}, {32'd2, 32'd14});
        step(2);

        // Random operands against the language's own division.
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            rb = (k < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (rb == 32'd0) rb = 32'd3;
            if (k[0]) begin
                if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) ra = 32'd5;
                sa = $signed(ra); sbv = $signed(rb);
                run_div(1'b1, ra, rb, {32'(sa % sbv), 32'(sa / sbv)}, 33);
            end else begin
                run_div(1'b0, ra, rb, {ra % rb, ra / rb}, 33);
            end
        end

        // Reset mid-divide: nothing may be written afterwards.
        start_div(1'b0, 32'd100, 32'd7);
        step(19);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset_hilo", {hi, lo}, 64'd0);
        check("midreset_flags", {62'd0, div_busy, div_done}, 64'd0);
        step(40);
        check("midreset_quiet", {hi, lo}, 64'd0);

        check("spurious_done", 64'(n_spurious), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
